// File: rtl/z80_bus_bridge.sv
// z80_bus_bridge
// Converts tv80s-style CPU bus cycles into a simple level request/ack
// handshake. The CPU is stalled with wait_n until the downstream side
// acknowledges, or until a cycle budget runs out and the cycle is forced
// to complete with 8'hFF read data and a sticky error flag.
//
// Ports
//   clk, reset        : single clock, synchronous active-high reset
//   mreq_n .. rfsh_n  : CPU bus strobes (active-low)
//   A, dout           : CPU address and write data
//   di, wait_n        : read data and wait request back to the CPU
//   req, we, is_io    : downstream request level, write flag, I/O-space flag
//   addr, wdata       : downstream address and write data
//   ack, rdata        : downstream one-cycle completion and its read data
//   err, err_clr      : sticky timeout flag and its clear
module z80_bus_bridge #(
  parameter logic [7:0] IO_PAGE = 8'h10,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic        rfsh_n,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  output logic [7:0]  di,
  output logic        wait_n,
  output logic        req,
  output logic        we,
  output logic        is_io,
  output logic [15:0] addr,
  output logic [7:0]  wdata,
  input  logic        ack,
  input  logic [7:0]  rdata,
  output logic        err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  cnt_q;
  logic [7:0]  di_q;
  logic        start;
  logic        inta;
  logic        timeout_hit;
  logic        timeout_evt;

  // Refresh cycles and interrupt acknowledge are excluded from start.
  assign start = rfsh_n & (~mreq_n | (~iorq_n & m1_n)) & (~rd_n | ~wr_n);
  assign inta  = ~m1_n & ~iorq_n;

  // cnt_q counts completed REQ cycles, so the budget is spent when this
  // cycle would be number TIMEOUT. A zero budget therefore still gives one
  // REQ cycle. Compared in 9 bits so TIMEOUT=0 needs no special case.
  assign timeout_hit = ({1'b0, cnt_q} + 9'd1) >= {1'b0, TIMEOUT};
  assign timeout_evt = (state_q == REQ) && !ack && timeout_hit;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ack takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = REQ;
      REQ:  if (ack || timeout_hit) state_d = DONE;
      DONE: if (rd_n && wr_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction capture, timeout counter and read-data return.
  always_ff @(posedge clk) begin
    if (reset) begin
      we    <= 1'b0;
      is_io <= 1'b0;
      addr  <= 16'h0000;
      wdata <= 8'h00;
      di_q  <= 8'hFF;
      cnt_q <= 8'd0;
    end else begin
      if (state_q == IDLE && start) begin
        we    <= ~wr_n;
        is_io <= ~iorq_n;
        wdata <= dout;
        addr  <= (~iorq_n) ? {IO_PAGE, A[7:0]} : A;
        cnt_q <= 8'd0;
      end
      if (state_q == REQ) begin
        if (ack) begin
          if (!we) di_q <= rdata;
        end else if (timeout_hit) begin
          if (!we) di_q <= 8'hFF;
        end else if (cnt_q != TIMEOUT) begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

  // Sticky error; a timeout in the same cycle beats err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (timeout_evt) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  assign req    = (state_q == REQ);
  assign di     = inta ? 8'hFF : di_q;
  assign wait_n = reset ? 1'b1 : !((state_q == IDLE && start) || state_q == REQ);

endmodule

// File: tb/tb_z80_bus_bridge.sv
// tb_z80_bus_bridge
// Self-checking bench for z80_bus_bridge (TIMEOUT set to 4). Each scenario
// task drives CPU/downstream stimulus and compares outputs against a small
// transaction-level model (expected di, err, request length).
module tb_z80_bus_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
  logic [15:0] A;
  logic [7:0]  dout;
  logic [7:0]  di;
  logic        wait_n;
  logic        req, we, is_io;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ack;
  logic [7:0]  rdata;
  logic        err;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_di;
  logic       exp_err;

  z80_bus_bridge #(.IO_PAGE(8'h10), .TIMEOUT(8'(TO))) dut (
    .clk(clk), .reset(reset),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .m1_n(m1_n), .rfsh_n(rfsh_n),
    .A(A), .dout(dout), .di(di), .wait_n(wait_n),
    .req(req), .we(we), .is_io(is_io), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic bus_idle();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    m1_n = 1'b1; rfsh_n = 1'b1;
  endtask

  // One complete CPU cycle. ack_at = REQ cycle (1-based) carrying ack,
  // 0 = never. hold = extra cycles the strobes stay low in DONE.
  // clr = err_clr held high for the whole transaction.
  task automatic run_txn(input string name, input bit io, input bit wr,
                         input logic [15:0] a, input logic [7:0] d,
                         input int ack_at, input logic [7:0] rd,
                         input int hold, input bit clr);
    logic [15:0] exp_addr;
    int req_cycles, wait_low, exp_req;
    bit acked, seen_done;
    exp_addr = io ? {8'h10, a[7:0]} : a;
    acked    = (ack_at >= 1) && (ack_at <= TO);
    exp_req  = acked ? ack_at : TO;
    @(posedge clk); #1;
    A = a; dout = d; rfsh_n = 1'b1; m1_n = 1'b1;
    mreq_n = io; iorq_n = !io; rd_n = wr; wr_n = !wr; ack = 1'b0;
    err_clr = clr;
    req_cycles = 0; wait_low = 0; seen_done = 0;
    for (int i = 0; i < 20 && !seen_done; i++) begin
      @(negedge clk);
      if (!wait_n) wait_low++;
      if (req) begin
        req_cycles++;
        checks++;
        if ({addr, we, is_io, wdata} !== {exp_addr, wr, io, d}) begin
          errors++;
          $display("[TB] FAIL %s fields got addr=%h we=%b io=%b wdata=%h expected addr=%h we=%b io=%b wdata=%h",
                   name, addr, we, is_io, wdata, exp_addr, wr, io, d);
        end
        ack   = (req_cycles == ack_at);
        rdata = ack ? rd : 8'($urandom);
      end else begin
        ack = 1'b0;
        if (req_cycles > 0) seen_done = 1;
      end
    end
    checks++;
    if (!seen_done) begin
      errors++;
      $display("[TB] FAIL %s no_completion got req_cycles=%0d expected done", name, req_cycles);
    end
    checks++;
    if (req_cycles != exp_req) begin
      errors++;
      $display("[TB] FAIL %s req_len got %0d expected %0d", name, req_cycles, exp_req);
    end
    checks++;
    if (wait_low != exp_req + 1) begin
      errors++;
      $display("[TB] FAIL %s wait_len got %0d expected %0d", name, wait_low, exp_req + 1);
    end
    if (!wr) exp_di = acked ? rd : 8'hFF;
    if (!acked) exp_err = 1'b1;
    else if (clr) exp_err = 1'b0;
    checks++;
    if ({di, err, wait_n} !== {exp_di, exp_err, 1'b1}) begin
      errors++;
      $display("[TB] FAIL %s done got di=%h err=%b wait_n=%b expected di=%h err=%b wait_n=1",
               name, di, err, wait_n, exp_di, exp_err);
    end
    err_clr = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if ({req, wait_n} !== 2'b01) begin
        errors++;
        $display("[TB] FAIL %s hold got req=%b wait_n=%b expected req=0 wait_n=1", name, req, wait_n);
      end
    end
    bus_idle();
    @(negedge clk);
    checks++;
    if ({req, wait_n, di, err} !== {1'b0, 1'b1, exp_di, exp_err}) begin
      errors++;
      $display("[TB] FAIL %s idle got req=%b wait_n=%b di=%h err=%b expected req=0 wait_n=1 di=%h err=%b",
               name, req, wait_n, di, err, exp_di, exp_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_idle();
    mreq_n = 1'b0; rd_n = 1'b0; A = 16'hABCD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req, we, is_io, addr, wdata, di, err, wait_n} !==
        {1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hFF, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset got req=%b we=%b io=%b addr=%h wdata=%h di=%h err=%b wait_n=%b expected 0 0 0 0000 00 ff 0 1",
               req, we, is_io, addr, wdata, di, err, wait_n);
    end
    bus_idle();
    reset = 1'b0;
    exp_di = 8'hFF; exp_err = 1'b0;
  endtask

  task automatic test_mem_read();
    run_txn("mem_read", 1'b0, 1'b0, 16'h6FF5, 8'h00, 3, 8'hF6, 0, 1'b0);
  endtask

  task automatic test_io_write();
    run_txn("io_write", 1'b1, 1'b1, 16'h1234, 8'h5A, 2, 8'h11, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 1'b0, 1'b0, 16'h8001, 8'h00, 0, 8'h00, 0, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("[TB] FAIL err_clr got %b expected %b", err, exp_err);
    end
    // err_clr held through a timing-out read: the timeout must win.
    run_txn("clr_race", 1'b0, 1'b0, 16'h2222, 8'h00, 0, 8'h00, 0, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic test_ack_timeout_tie();
    run_txn("ack_tie", 1'b0, 1'b0, 16'h0F0F, 8'h00, TO, 8'h3C, 0, 1'b0);
  endtask

  task automatic test_refresh_inta();
    for (int k = 0; k < 2; k++) begin
      bus_idle();
      mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = k[0];
      repeat (3) begin
        @(negedge clk);
        checks++;
        if ({req, wait_n} !== 2'b01) begin
          errors++;
          $display("[TB] FAIL refresh got req=%b wait_n=%b expected req=0 wait_n=1", req, wait_n);
        end
      end
    end
    bus_idle();
    m1_n = 1'b0; iorq_n = 1'b0;
    repeat (3) begin
      #1;
      checks++;
      if ({req, wait_n, di} !== {1'b0, 1'b1, 8'hFF}) begin
        errors++;
        $display("[TB] FAIL inta got req=%b wait_n=%b di=%h expected req=0 wait_n=1 di=ff", req, wait_n, di);
      end
      @(negedge clk);
    end
    bus_idle();
    #1;
    checks++;
    if (di !== exp_di) begin
      errors++;
      $display("[TB] FAIL inta_release got di=%h expected %h", di, exp_di);
    end
  endtask

  task automatic test_ack_ignored();
    @(negedge clk);
    ack = 1'b1; rdata = 8'h99;
    repeat (2) @(negedge clk);
    ack = 1'b0;
    checks++;
    if ({req, di, err} !== {1'b0, exp_di, exp_err}) begin
      errors++;
      $display("[TB] FAIL ack_idle got req=%b di=%h err=%b expected req=0 di=%h err=%b", req, di, err, exp_di, exp_err);
    end
  endtask

  task automatic test_reset_in_req();
    @(posedge clk); #1;
    A = 16'h4444; mreq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_req_pre got req=%b expected 1", req);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (wait_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_wait got wait_n=%b expected 1", wait_n);
    end
    @(negedge clk);
    checks++;
    if ({req, di} !== {1'b0, 8'hFF}) begin
      errors++;
      $display("[TB] FAIL rst_req got req=%b di=%h expected req=0 di=ff", req, di);
    end
    reset = 1'b0;
    bus_idle();
    exp_di = 8'hFF; exp_err = 1'b0;
    ack = 1'b1; rdata = 8'h77;
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if ({req, di} !== {1'b0, 8'hFF}) begin
      errors++;
      $display("[TB] FAIL rst_late_ack got req=%b di=%h expected req=0 di=ff", req, di);
    end
    run_txn("after_reset", 1'b0, 1'b0, 16'h5151, 8'h00, 1, 8'hA5, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_first", 1'b0, 1'b0, 16'h7000, 8'h00, 2, 8'h12, 5, 1'b0);
    run_txn("b2b_second", 1'b0, 1'b0, 16'h7001, 8'h00, 1, 8'h34, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      run_txn("random", 1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom),
              int'($urandom_range(0, 6)), 8'($urandom), int'($urandom_range(0, 2)), 1'b0);
      if (exp_err) begin
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; ack = 1'b0; rdata = 8'h00; err_clr = 1'b0;
    A = 16'h0000; dout = 8'h00;
    exp_di = 8'hFF; exp_err = 1'b0;
    bus_idle();
    test_reset();
    test_mem_read();
    test_io_write();
    test_timeout();
    test_ack_timeout_tie();
    test_refresh_inta();
    test_ack_ignored();
    test_reset_in_req();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
